pipe_scroller: RTL and testbench

Obstacle side of the Flappy Bird 8x8 LED game. Generates pipe columns with a pseudo-random gap, scrolls them one column left per game tick, and checks the pipe pixels in the bird column against the bird's row lights. It drives `lossDetect` back to the bird cells and keeps a saturating score. It sits between the per-row bird cells (their `lightOn` outputs feed `birdRows`) and the LED matrix driver (red plane).

---
 rtl/flappy_pkg.sv | 26 ++
 rtl/pipe_gen.sv | 45 ++++
 rtl/pipe_scroller.sv | 144 ++++++++++++++
 tb/tb_pipe_scroller.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | flappy_pkg : shared types and constants for the Flappy Bird LED game |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LOST = 2'd2
  } state_t;

  localparam int ROWS = 8;
  localparam int COLS = 8;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // x^8+x^6+x^5+x^4+1: stages 8,6,5,4 sit in bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_gen : LFSR-driven pipe column generator (gap decode)            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pipe_gen
  import flappy_pkg::*;
#(
  parameter int GAP_H = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       advance,
  output logic [7:0] column
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;
  int         gap_top;

  always_comb begin
    lfsr_d = advance ? lfsr_next(lfsr_q) : lfsr_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Gap is clamped so it always fits fully inside the column.
  always_comb begin
    gap_top = (int'(lfsr_q[2:0]) > ROWS - GAP_H) ? ROWS - GAP_H : int'(lfsr_q[2:0]);
    column  = '1;
    for (int r = 0; r < ROWS; r++) begin
      if ((r >= gap_top) && (r < gap_top + GAP_H)) begin
        column[r] = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_scroller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_scroller : scrolling pipe field, collision and score            |
// | Option macro PIPE_SCORE_EN enables the saturating score counter.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pipe_scroller
  import flappy_pkg::*;
#(
  parameter logic [10:0] TICK_MAX     = 11'd1791,
  parameter int          PIPE_SPACING = 4,
  parameter int          GAP_H        = 3,
  parameter int          BIRD_COL     = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  birdRows,
  output logic [63:0] pipeCols,
  output logic        lossDetect,
  output logic [7:0]  score
);

  localparam int SW = $clog2(PIPE_SPACING);

  state_t           state_q, state_d;
  logic [10:0]      tick_q, tick_d;
  logic [SW-1:0]    space_q, space_d;
  logic [63:0]      grid_q, grid_d;
  logic             loss_q, loss_d;

  logic             w_run;
  logic             w_tick;
  logic             w_collide;
  logic             w_step;
  logic             w_clear;
  logic             w_insert;
  logic [7:0]       w_pipe;
  logic [7:0]       w_bird_col;

  assign w_run      = (state_q == RUN);
  assign w_bird_col = grid_q[8*BIRD_COL +: 8];
  assign w_tick     = w_run && (tick_q == TICK_MAX);
  assign w_collide  = w_run && ((|(w_bird_col & birdRows)) || (birdRows == 8'h00));
  assign w_step     = w_tick && !w_collide;
  assign w_insert   = w_step && (space_q == '0);

  pipe_gen #(
    .GAP_H (GAP_H)
  ) u_pipe_gen (
    .clock   (clock),
    .reset   (reset),
    .advance (w_insert),
    .column  (w_pipe)
  );

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    space_d = space_q;
    grid_d  = grid_q;
    w_clear = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          w_clear = 1'b1;
        end
      end
      RUN: begin
        if (w_collide) begin
          state_d = LOST;
        end else begin
          tick_d = w_tick ? 11'd0 : tick_q + 11'd1;
          if (w_tick) begin
            // Column 0 is the low byte, so a right shift moves pipes left.
            grid_d  = {(w_insert ? w_pipe : 8'h00), grid_q[63:8]};
            space_d = (space_q == SW'(PIPE_SPACING - 1)) ? '0 : space_q + SW'(1);
          end
        end
      end
      LOST: begin
        if (start) begin
          state_d = RUN;
          w_clear = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (w_clear) begin
      tick_d  = '0;
      space_d = '0;
      grid_d  = '0;
    end
    loss_d = (state_d == LOST);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      space_q <= '0;
      grid_q  <= '0;
      loss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      space_q <= space_d;
      grid_q  <= grid_d;
      loss_q  <= loss_d;
    end
  end

  assign pipeCols   = grid_q;
  assign lossDetect = loss_q;

`ifdef PIPE_SCORE_EN
  logic [7:0] score_q, score_d;

  // A pipe in the bird column on a clean tick is about to be passed.
  always_comb begin
    score_d = score_q;
    if (w_clear) begin
      score_d = 8'h00;
    end else if (w_step && (|w_bird_col) && (score_q != 8'hFF)) begin
      score_d = score_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      score_q <= 8'h00;
    end else begin
      score_q <= score_d;
    end
  end

  assign score = score_q;
`else
  assign score = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_scroller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipe_scroller : scoreboard bench for pipe_scroller (TICK_MAX=3)   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pipe_scroller;

`ifdef PIPE_SCORE_EN
  localparam logic [7:0] SCORE_ONE = 8'd1;
`else
  localparam logic [7:0] SCORE_ONE = 8'd0;
`endif

  localparam logic [63:0] G_TICK1_A = 64'h1F00_0000_0000_0000;
  localparam logic [63:0] G_TICK7   = 64'h0000_E300_0000_1F00;
  localparam logic [63:0] G_TICK8   = 64'h0000_00E3_0000_001F;
  localparam logic [63:0] G_TICK5_F = 64'hE300_0000_1F00_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  birdRows = 8'h00;
  logic [63:0] pipeCols;
  logic        lossDetect;
  logic [7:0]  score;

  pipe_scroller #(
    .TICK_MAX     (11'd3),
    .PIPE_SPACING (4),
    .GAP_H        (3),
    .BIRD_COL     (1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .birdRows   (birdRows),
    .pipeCols   (pipeCols),
    .lossDetect (lossDetect),
    .score      (score)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    string       name;
    logic [63:0] grid;
    logic        loss;
    logic [7:0]  score;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total  = 0;
  int   passed = 0;

  task automatic expect_at(input int c, input string n, input logic [63:0] g,
                           input logic l, input logic [7:0] s);
    exp_t x;
    x.cyc = c; x.name = n; x.grid = g; x.loss = l; x.score = s;
    sb.push_back(x);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  // Monitor: compares registered outputs on the falling edge of each due cycle.
  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      total++;
      if (e.cyc != cyc) begin
        $display("FAIL %s: sample slot missed (due cycle %0d, now %0d)", e.name, e.cyc, cyc);
      end else begin
        if (pipeCols === e.grid) passed++;
        else $display("FAIL %s pipeCols: got %h expected %h", e.name, pipeCols, e.grid);
        total++;
        if (lossDetect === e.loss) passed++;
        else $display("FAIL %s lossDetect: got %b expected %b", e.name, lossDetect, e.loss);
        total++;
        if (score === e.score) passed++;
        else $display("FAIL %s score: got %0d expected %0d", e.name, score, e.score);
      end
    end
  end

  int b;
  int b2;
  int b3;

  initial begin
    // Reset held for two edges, then idle with no start.
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    expect_at(cyc + 1,  "rst_idle1",  64'h0, 1'b0, 8'h00);
    expect_at(cyc + 10, "rst_idle10", 64'h0, 1'b0, 8'h00);
    expect_at(cyc + 20, "rst_idle20", 64'h0, 1'b0, 8'h00);
    wait_to(cyc + 21);

    // Game A: first pipe gap at row 5, then bird at row 0 hits it in column 1.
    start = 1'b1; birdRows = 8'h20;
    b = cyc + 1;
    expect_at(b,      "A_start",  64'h0,     1'b0, 8'h00);
    expect_at(b + 4,  "A_tick1",  G_TICK1_A, 1'b0, 8'h00);
    expect_at(b + 28, "A_tick7",  G_TICK7,   1'b0, 8'h00);
    expect_at(b + 29, "A_loss",   G_TICK7,   1'b1, 8'h00);
    expect_at(b + 40, "A_frozen", G_TICK7,   1'b1, 8'h00);
    expect_at(b + 49, "A_frz_end",G_TICK7,   1'b1, 8'h00);
    @(negedge clock);
    start = 1'b0;
    wait_to(b + 5);
    birdRows = 8'h01;
    wait_to(b + 50);

    // Reset out of LOST.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    expect_at(cyc + 1, "rst_from_lost", 64'h0, 1'b0, 8'h00);
    @(negedge clock);

    // Game B: bird flies through the gap, score on tick 8; stray start ignored.
    start = 1'b1; birdRows = 8'h20;
    b = cyc + 1;
    expect_at(b + 28, "B_tick7", G_TICK7, 1'b0, 8'h00);
    expect_at(b + 32, "B_tick8", G_TICK8, 1'b0, SCORE_ONE);
    expect_at(b + 33, "B_hold",  G_TICK8, 1'b0, SCORE_ONE);
    expect_at(b + 34, "C_loss",  G_TICK8, 1'b1, SCORE_ONE);
    expect_at(b + 37, "C_restart", 64'h0, 1'b0, 8'h00);
    @(negedge clock);
    start = 1'b0;
    wait_to(b + 10);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_to(b + 33);
    birdRows = 8'h00;
    wait_to(b + 36);
    start = 1'b1; birdRows = 8'h20;
    @(negedge clock);
    start = 1'b0;

    // Game D: LFSR continues (0x95 -> gap 5), then reset wins over start on tick 5.
    b2 = b + 37;
    expect_at(b2 + 4,  "D_tick1", G_TICK1_A, 1'b0, 8'h00);
    expect_at(b2 + 20, "E_reset", 64'h0,     1'b0, 8'h00);
    wait_to(b2 + 19);
    reset = 1'b1; start = 1'b1;
    @(negedge clock);
    reset = 1'b0; start = 1'b0;
    expect_at(cyc + 5, "E_idle", 64'h0, 1'b0, 8'h00);
    wait_to(cyc + 6);

    // Game F: LFSR back at seed gives the same pipe sequence as game A.
    start = 1'b1; birdRows = 8'h20;
    b3 = cyc + 1;
    expect_at(b3 + 4,  "F_tick1", G_TICK1_A, 1'b0, 8'h00);
    expect_at(b3 + 20, "F_tick5", G_TICK5_F, 1'b0, 8'h00);
    @(negedge clock);
    start = 1'b0;
    wait_to(b3 + 21);

    for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clock);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      $display("FAIL %s: never sampled (due cycle %0d)", e.name, e.cyc);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete, got timeout required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
